// File: rtl/sprite_palette_pkg.sv
// Shared types, constants and the colour-cycle index remap for the sprite palette lookup.
package sprite_palette_pkg;

  localparam int BANK_W      = 4;
  localparam int RGB_COLOR_W = 4;

  typedef struct packed {
    logic [RGB_COLOR_W-1:0] red;
    logic [RGB_COLOR_W-1:0] green;
    logic [RGB_COLOR_W-1:0] blue;
  } rgb_t;

  // Rotates idx within [lo, hi] by offset; offset < len, so one conditional subtract suffices.
  function automatic logic [15:0] cyc_map(input logic [15:0] idx,
                                          input logic [15:0] offset,
                                          input logic [15:0] lo,
                                          input logic [15:0] hi);
    logic [15:0] len;
    logic [15:0] rel;
    len = hi - lo + 16'd1;
    if ((idx < lo) || (idx > hi)) begin
      return idx;
    end
    rel = idx - lo + offset;
    if (rel >= len) begin
      rel = rel - len;
    end
    return lo + rel;
  endfunction

endpackage

// File: rtl/sprite_palette_lut_cycle_ctrl.sv
// Frame counter and colour-cycle offset; both clear every cycle while cycling is disabled.
module palette_cycle_ctrl
  import sprite_palette_pkg::*;
#(
  parameter int CYC_PERIOD = 8,
  parameter int LEN        = 4,
  parameter int OFF_W      = 4
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             frame_start,
  input  logic             cyc_en,
  output logic [OFF_W-1:0] offset
);

  localparam int CNT_W = (CYC_PERIOD > 1) ? $clog2(CYC_PERIOD) : 1;

  logic [CNT_W-1:0] frame_cnt;
  logic [OFF_W:0]   off_inc;

  // One spare bit so LEN == 2^OFF_W still wraps correctly
  assign off_inc = {1'b0, offset} + (OFF_W+1)'(1);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_cnt <= '0;
      offset    <= '0;
    end else if (!cyc_en) begin
      frame_cnt <= '0;
      offset    <= '0;
    end else if (frame_start) begin
      if (int'(frame_cnt) == CYC_PERIOD - 1) begin
        frame_cnt <= '0;
        offset    <= (int'(off_inc) == LEN) ? '0 : off_inc[OFF_W-1:0];
      end else begin
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sprite_palette_lut.sv
// Runtime-writable banked sprite palette with 2-cycle lookup, transparency key and colour cycling.
module sprite_palette_lut
  import sprite_palette_pkg::*;
#(
  parameter int INDEX_W    = 4,
  parameter int COLOR_W    = 4,
  parameter int NUM_BANKS  = 4,
  parameter int TRANS_IDX  = 0,
  parameter int CYC_LO     = 12,
  parameter int CYC_HI     = 15,
  parameter int CYC_PERIOD = 8
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 frame_start,
  input  logic [BANK_W-1:0]    bank_sel,
  input  logic                 cyc_en,
  input  logic                 pix_valid,
  input  logic [INDEX_W-1:0]   pix_index,
  input  logic                 wr_en,
  input  logic [BANK_W-1:0]    wr_bank,
  input  logic [INDEX_W-1:0]   wr_addr,
  input  logic [3*COLOR_W-1:0] wr_data,
  output logic                 out_valid,
  output logic [COLOR_W-1:0]   red,
  output logic [COLOR_W-1:0]   green,
  output logic [COLOR_W-1:0]   blue,
  output logic                 transparent,
  output logic [BANK_W-1:0]    active_bank
);

  localparam int ENTRIES = 2 ** INDEX_W;
  localparam int RGB_W   = 3 * COLOR_W;
  localparam int LEN     = CYC_HI - CYC_LO + 1;
  localparam int SEL_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  logic [RGB_W-1:0]   pal [NUM_BANKS][ENTRIES];
  logic [INDEX_W-1:0] offset;
  logic               wr_ok;
  logic               sel_ok;

  logic               vld_p1;
  logic [INDEX_W-1:0] idx_p1;
  logic [SEL_W-1:0]   bank_p1;
  logic [INDEX_W-1:0] mapped_p1;
  logic [RGB_W-1:0]   entry_p1;
  logic               trans_p1;

  palette_cycle_ctrl #(
    .CYC_PERIOD (CYC_PERIOD),
    .LEN        (LEN),
    .OFF_W      (INDEX_W)
  ) u_cycle (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_start (frame_start),
    .cyc_en      (cyc_en),
    .offset      (offset)
  );

  assign wr_ok  = wr_en && (int'(wr_bank) < NUM_BANKS);
  assign sel_ok = frame_start && (int'(bank_sel) < NUM_BANKS);

  // Reads below see pre-edge contents, giving read-before-write on a same-entry collision
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int e = 0; e < ENTRIES; e++) begin
          pal[b][e] <= '0;
        end
      end
    end else if (wr_ok) begin
      pal[wr_bank[SEL_W-1:0]][wr_addr] <= wr_data;
    end
  end

  // Stage 1: capture pixel and the bank in force before any switch on this edge
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      active_bank <= '0;
      vld_p1      <= 1'b0;
      idx_p1      <= '0;
      bank_p1     <= '0;
    end else begin
      if (sel_ok) begin
        active_bank <= bank_sel;
      end
      vld_p1  <= pix_valid;
      idx_p1  <= pix_index;
      bank_p1 <= active_bank[SEL_W-1:0];
    end
  end

  assign mapped_p1 = INDEX_W'(cyc_map(16'(idx_p1), 16'(offset), 16'(CYC_LO), 16'(CYC_HI)));
  assign entry_p1  = pal[bank_p1][mapped_p1];
  assign trans_p1  = (idx_p1 == INDEX_W'(TRANS_IDX));

  // Stage 2: remap, read and register outputs; colours hold while no pixel is present
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      out_valid   <= 1'b0;
      transparent <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
    end else begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        transparent <= trans_p1;
        if (trans_p1) begin
          {red, green, blue} <= '0;
        end else begin
          {red, green, blue} <= entry_p1;
        end
      end
    end
  end

endmodule
